// File: rtl/vga_sync_gen_param.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen_param
//  Description : Parametrised VGA timing generator. Produces a pixel strobe,
//                horizontal/vertical sync, video_on, pixel coordinates and
//                line/frame start strobes. Pixel rate = CLK / CLK_DIV.
//                Optional macro VGA_FRAME_CNT_EN adds a 16-bit frame counter
//                output (frame_cnt).
//  Revision    : 1.0  initial release
// ============================================================================
module vga_sync_gen_param #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 10
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          enable,
    output logic          p_tick,
    output logic          sync_h,
    output logic          sync_v,
    output logic          video_on,
    output logic [CW-1:0] pixel_X,
    output logic [CW-1:0] pixel_Y,
    output logic          line_start,
`ifdef VGA_FRAME_CNT_EN
    output logic [15:0]   frame_cnt,
`endif
    output logic          frame_start
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Divider needs at least one bit even when CLK_DIV is 1
    localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_DIV - 1);
    localparam logic [CW-1:0] c_h_last     = CW'(c_h_total - 1);
    localparam logic [CW-1:0] c_v_last     = CW'(c_v_total - 1);
    localparam logic [CW-1:0] c_h_act      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_v_act      = CW'(V_ACTIVE);
    // Inclusive sync windows avoid needing a CW+1 bit end bound
    localparam logic [CW-1:0] c_hs_first   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_hs_last    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] c_vs_first   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_vs_last    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          c_hs_on      = (HS_POL != 0);
    localparam logic          c_vs_on      = (VS_POL != 0);

    logic [c_div_w-1:0] div_q, div_d;
    logic [CW-1:0]      x_q, x_d;
    logic [CW-1:0]      y_q, y_d;
    logic               sync_h_q, sync_h_d;
    logic               sync_v_q, sync_v_d;
    logic               video_on_q, video_on_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic               w_tick;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]        frame_cnt_q, frame_cnt_d;
`endif

    // Next-state: divider, counters, and sync/video/strobes from next counts
    always_comb begin
        w_tick        = enable && (div_q == c_div_max);
        div_d         = div_q;
        x_d           = x_q;
        y_d           = y_q;
        sync_h_d      = sync_h_q;
        sync_v_d      = sync_v_q;
        video_on_d    = video_on_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (enable) begin
            div_d = (div_q == c_div_max) ? '0 : div_q + 1'b1;
            if (w_tick) begin
                if (x_q == c_h_last) begin
                    x_d           = '0;
                    y_d           = (y_q == c_v_last) ? '0 : y_q + 1'b1;
                    line_start_d  = 1'b1;
                    frame_start_d = (y_q == c_v_last);
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            sync_h_d   = ((x_d >= c_hs_first) && (x_d <= c_hs_last)) ? c_hs_on : ~c_hs_on;
            sync_v_d   = ((y_d >= c_vs_first) && (y_d <= c_vs_last)) ? c_vs_on : ~c_vs_on;
            video_on_d = (x_d < c_h_act) && (y_d < c_v_act);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter advances together with the frame_start strobe
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end
`endif

    // State register; reset overrides enable
    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            sync_h_q      <= ~c_hs_on;
            sync_v_q      <= ~c_vs_on;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            sync_h_q      <= sync_h_d;
            sync_v_q      <= sync_v_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter register, wraps naturally at 16 bits
    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    // Pixel strobe is combinational so that CLK_DIV=1 gives p_tick=enable;
    // it is masked while reset is held
    assign p_tick      = w_tick && !RESET;
    assign sync_h      = sync_h_q;
    assign sync_v      = sync_v_q;
    assign video_on    = video_on_q;
    assign pixel_X     = x_q;
    assign pixel_Y     = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_gen_param
//  Description : Directed self-checking bench for vga_sync_gen_param. One
//                instance uses the default 640x480 timing, a second uses a
//                small 15x8 geometry with CLK_DIV=1 and active-high syncs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_sync_gen_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Default-mode instance
    logic       rst_d, en_d;
    logic       d_p_tick, d_sync_h, d_sync_v, d_video_on, d_line_start, d_frame_start;
    logic [9:0] d_x, d_y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] d_frame_cnt;
`endif

    // Small-geometry instance: H_TOTAL=15 (sync X=10..12), V_TOTAL=8 (sync Y=5..6)
    logic       rst_p, en_p;
    logic       p_p_tick, p_sync_h, p_sync_v, p_video_on, p_line_start, p_frame_start;
    logic [3:0] p_x, p_y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] p_frame_cnt;
`endif

    vga_sync_gen_param u_dut_def (
        .CLK         (clk),
        .RESET       (rst_d),
        .enable      (en_d),
        .p_tick      (d_p_tick),
        .sync_h      (d_sync_h),
        .sync_v      (d_sync_v),
        .video_on    (d_video_on),
        .pixel_X     (d_x),
        .pixel_Y     (d_y),
        .line_start  (d_line_start),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt   (d_frame_cnt),
`endif
        .frame_start (d_frame_start)
    );

    vga_sync_gen_param #(
        .CLK_DIV (1),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL  (1), .VS_POL(1), .CW(4)
    ) u_dut_small (
        .CLK         (clk),
        .RESET       (rst_p),
        .enable      (en_p),
        .p_tick      (p_p_tick),
        .sync_h      (p_sync_h),
        .sync_v      (p_sync_v),
        .video_on    (p_video_on),
        .pixel_X     (p_x),
        .pixel_Y     (p_y),
        .line_start  (p_line_start),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt   (p_frame_cnt),
`endif
        .frame_start (p_frame_start)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_d;
        rst_d = 1'b1;
        repeat (2) step();
        rst_d = 1'b0;
    endtask

    task automatic do_reset_p;
        rst_p = 1'b1;
        repeat (2) step();
        rst_p = 1'b0;
    endtask

    task automatic test_reset;
        rst_d = 1'b1; en_d = 1'b1;
        rst_p = 1'b1; en_p = 1'b1;
        repeat (3) step();
        n_tests++;
        if ({d_p_tick, d_sync_h, d_sync_v, d_video_on, d_line_start, d_frame_start} !== 6'b011000) begin
            n_fail++;
            $display("FAIL reset_def_flags: got %b want 011000",
                     {d_p_tick, d_sync_h, d_sync_v, d_video_on, d_line_start, d_frame_start});
        end
        n_tests++;
        if (d_x !== 10'd0 || d_y !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_def_xy: got X=%0d Y=%0d want 0 0", d_x, d_y);
        end
        n_tests++;
        if ({p_p_tick, p_sync_h, p_sync_v, p_video_on, p_line_start, p_frame_start} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_small_flags: got %b want 000000",
                     {p_p_tick, p_sync_h, p_sync_v, p_video_on, p_line_start, p_frame_start});
        end
`ifdef VGA_FRAME_CNT_EN
        n_tests++;
        if (p_frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_frame_cnt: got %0d want 0", p_frame_cnt);
        end
`endif
        rst_d = 1'b0;
        step();
        n_tests++;
        if (d_video_on !== 1'b1 || d_x !== 10'd0 || d_line_start !== 1'b0) begin
            n_fail++;
            $display("FAIL release_video_on: got vo=%b X=%0d ls=%b want 1 0 0",
                     d_video_on, d_x, d_line_start);
        end
    endtask

    task automatic test_hsync_line;
        int bad_xy = 0, bad_hs = 0, bad_vs = 0, bad_vo = 0, bad_pt = 0;
        int first_ls = -1, n_ls = 0, n_fs = 0, hs_low = 0;
        int xm, ym;
        en_d = 1'b1;
        do_reset_d();
        for (int s = 1; s <= 6400; s++) begin
            step();
            xm = (s / 4) % 800;
            ym = s / 3200;
            if (d_x !== 10'(xm) || d_y !== 10'(ym)) bad_xy++;
            if (d_sync_h !== !(xm >= 656 && xm <= 751)) bad_hs++;
            if (d_sync_v !== 1'b1) bad_vs++;
            if (d_video_on !== (xm < 640)) bad_vo++;
            if (d_p_tick !== ((s % 4) == 3)) bad_pt++;
            if (d_line_start === 1'b1) begin
                if (first_ls < 0) first_ls = s;
                n_ls++;
            end
            if (d_frame_start === 1'b1) n_fs++;
            if (s < 3200 && d_sync_h === 1'b0) hs_low++;
        end
        n_tests++; if (bad_xy != 0) begin n_fail++; $display("FAIL def_xy_track: bad=%0d want 0", bad_xy); end
        n_tests++; if (bad_hs != 0) begin n_fail++; $display("FAIL def_hsync_window: bad=%0d want 0", bad_hs); end
        n_tests++; if (bad_vs != 0) begin n_fail++; $display("FAIL def_vsync_idle: bad=%0d want 0", bad_vs); end
        n_tests++; if (bad_vo != 0) begin n_fail++; $display("FAIL def_video_on: bad=%0d want 0", bad_vo); end
        n_tests++; if (bad_pt != 0) begin n_fail++; $display("FAIL def_p_tick_period: bad=%0d want 0", bad_pt); end
        n_tests++; if (first_ls != 3200) begin n_fail++; $display("FAIL def_line_len: got %0d want 3200", first_ls); end
        n_tests++; if (n_ls != 2) begin n_fail++; $display("FAIL def_line_count: got %0d want 2", n_ls); end
        n_tests++; if (hs_low != 384) begin n_fail++; $display("FAIL def_hsync_width: got %0d want 384", hs_low); end
        n_tests++; if (n_fs != 0) begin n_fail++; $display("FAIL def_no_frame_start: got %0d want 0", n_fs); end
    endtask

    task automatic test_enable_freeze;
        int bad = 0;
        en_d = 1'b1;
        do_reset_d();
        for (int s = 1; s <= 401; s++) step();
        n_tests++;
        if (d_x !== 10'd100) begin
            n_fail++;
            $display("FAIL freeze_pre_x: got %0d want 100", d_x);
        end
        en_d = 1'b0;
        for (int j = 0; j < 37; j++) begin
            step();
            if (d_x !== 10'd100 || d_p_tick !== 1'b0 || d_line_start !== 1'b0 || d_video_on !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL freeze_hold: bad=%0d want 0", bad);
        end
        en_d = 1'b1;
        step();
        step();
        n_tests++;
        if (d_p_tick !== 1'b1 || d_x !== 10'd100) begin
            n_fail++;
            $display("FAIL freeze_resume_tick: got pt=%b X=%0d want 1 100", d_p_tick, d_x);
        end
        step();
        n_tests++;
        if (d_x !== 10'd101) begin
            n_fail++;
            $display("FAIL freeze_resume_x: got %0d want 101", d_x);
        end
    endtask

    task automatic test_clkdiv1_pol;
        int bad_xy = 0, bad_pt = 0, bad_hs = 0, bad_vs = 0, bad_vo = 0;
        int first_fs = -1, n_fs = 0, n_ls = 0, vo_cnt = 0;
        int xm, ym;
        en_p = 1'b1;
        do_reset_p();
        for (int s = 1; s <= 240; s++) begin
            step();
            xm = s % 15;
            ym = (s / 15) % 8;
            if (p_x !== 4'(xm) || p_y !== 4'(ym)) bad_xy++;
            if (p_p_tick !== 1'b1) bad_pt++;
            if (p_sync_h !== (xm >= 10 && xm <= 12)) bad_hs++;
            if (p_sync_v !== (ym >= 5 && ym <= 6)) bad_vs++;
            if (p_video_on !== (xm < 8 && ym < 4)) bad_vo++;
            if (s >= 120 && s < 240 && p_video_on === 1'b1) vo_cnt++;
            if (p_line_start === 1'b1) n_ls++;
            if (p_frame_start === 1'b1) begin
                if (first_fs < 0) first_fs = s;
                n_fs++;
            end
        end
        n_tests++; if (bad_xy != 0) begin n_fail++; $display("FAIL small_xy_track: bad=%0d want 0", bad_xy); end
        n_tests++; if (bad_pt != 0) begin n_fail++; $display("FAIL small_p_tick_const: bad=%0d want 0", bad_pt); end
        n_tests++; if (bad_hs != 0) begin n_fail++; $display("FAIL small_hsync_pos: bad=%0d want 0", bad_hs); end
        n_tests++; if (bad_vs != 0) begin n_fail++; $display("FAIL small_vsync_pos: bad=%0d want 0", bad_vs); end
        n_tests++; if (bad_vo != 0) begin n_fail++; $display("FAIL small_video_on: bad=%0d want 0", bad_vo); end
        n_tests++; if (vo_cnt != 32) begin n_fail++; $display("FAIL small_vo_per_frame: got %0d want 32", vo_cnt); end
        n_tests++; if (first_fs != 120) begin n_fail++; $display("FAIL small_frame_len: got %0d want 120", first_fs); end
        n_tests++; if (n_fs != 2) begin n_fail++; $display("FAIL small_frame_count: got %0d want 2", n_fs); end
        n_tests++; if (n_ls != 16) begin n_fail++; $display("FAIL small_line_count: got %0d want 16", n_ls); end
`ifdef VGA_FRAME_CNT_EN
        n_tests++; if (p_frame_cnt !== 16'd2) begin n_fail++; $display("FAIL small_frame_cnt: got %0d want 2", p_frame_cnt); end
`endif
    endtask

    task automatic test_reset_midframe;
        int n_fs = 0;
        en_p = 1'b1;
        do_reset_p();
        for (int s = 1; s <= 86; s++) step();
        n_tests++;
        if (p_x !== 4'd11 || p_y !== 4'd5 || p_sync_h !== 1'b1 || p_sync_v !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: got X=%0d Y=%0d hs=%b vs=%b want 11 5 1 1",
                     p_x, p_y, p_sync_h, p_sync_v);
        end
        rst_p = 1'b1;
        step();
        n_tests++;
        if ({p_p_tick, p_sync_h, p_sync_v, p_video_on, p_line_start, p_frame_start} !== 6'b000000
            || p_x !== 4'd0 || p_y !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_state: got flags=%b X=%0d Y=%0d want 000000 0 0",
                     {p_p_tick, p_sync_h, p_sync_v, p_video_on, p_line_start, p_frame_start}, p_x, p_y);
        end
        rst_p = 1'b0;
        for (int s = 1; s <= 15; s++) begin
            step();
            if (p_frame_start === 1'b1) n_fs++;
            if (s == 1) begin
                n_tests++;
                if (p_x !== 4'd1 || p_video_on !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midreset_restart: got X=%0d vo=%b want 1 1", p_x, p_video_on);
                end
            end
        end
        n_tests++;
        if (p_line_start !== 1'b1 || p_x !== 4'd0 || p_y !== 4'd1) begin
            n_fail++;
            $display("FAIL midreset_first_line: got ls=%b X=%0d Y=%0d want 1 0 1", p_line_start, p_x, p_y);
        end
        n_tests++;
        if (n_fs != 0) begin
            n_fail++;
            $display("FAIL midreset_no_frame_start: got %0d want 0", n_fs);
        end
    endtask

    initial begin
        rst_d = 1'b1; en_d = 1'b0;
        rst_p = 1'b1; en_p = 1'b0;
        test_reset();
        test_hsync_line();
        test_enable_freeze();
        test_clkdiv1_pol();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
